// File: rtl/swipt_sense_frontend.sv
// rtl/swipt_sense_frontend.sv - SWIPT receive-side sensing: heartbeat link detect, bridge-to-ADC filter model, hysteretic comparator
module swipt_sense_frontend #(
  parameter int HB_TIMEOUT = 256,
  parameter int HB_EDGES   = 4,
  parameter int K_SHIFT    = 4,
  parameter int HYST       = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptONHeartbeat,
  input  logic        SWIPT_OUT0,
  input  logic        SWIPT_OUT1,
  input  logic        SWIPT_OUT2,
  input  logic        SWIPT_OUT3,
  output logic        swipt,
  output logic [11:0] adc_code,
  output logic        ADC_comp
);

  localparam int GAP_W  = $clog2(HB_TIMEOUT + 1);
  localparam int EDGE_W = $clog2(HB_EDGES + 1);

  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(HB_TIMEOUT);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(HB_TIMEOUT - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(HB_EDGES);

  localparam logic [11:0] MIDSCALE = 12'd2048;
  localparam logic [11:0] FULL     = 12'd4095;
  localparam logic [11:0] ZERO     = 12'd0;
  localparam logic [11:0] CMP_HI   = 12'(2048 + HYST);
  localparam logic [11:0] CMP_LO   = 12'(2048 - HYST);

  // Heartbeat synchronizer and edge detector state
  logic s1, s2, s3;
  logic hb_edge;

  logic [GAP_W-1:0]  gap_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] edge_cnt_inc;

  // Analog model state
  logic [11:0]        acc;
  logic [11:0]        target;
  logic signed [12:0] diff;
  logic signed [12:0] shifted;
  logic signed [12:0] step;
  logic               shoot_through;

  assign hb_edge      = s2 ^ s3;
  assign edge_cnt_inc = edge_cnt + EDGE_W'(1);

  // Two-flop synchronizer for the asynchronous heartbeat plus one delay stage for edge detection
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= swiptONHeartbeat;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Gap counter, edge qualification and link-alive flag; an edge wins over a coincident timeout
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      gap_cnt  <= '0;
      edge_cnt <= '0;
      swipt    <= 1'b0;
    end else if (hb_edge) begin
      gap_cnt <= '0;
      if (!swipt) begin
        if (edge_cnt_inc == EDGE_LAST) begin
          swipt    <= 1'b1;
          edge_cnt <= '0;
        end else begin
          edge_cnt <= edge_cnt_inc;
        end
      end
    end else begin
      if (gap_cnt != GAP_MAX) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
      if (gap_cnt == GAP_LAST) begin
        swipt    <= 1'b0;
        edge_cnt <= '0;
      end
    end
  end

  // Bridge state decode: shoot-through pins the node at midscale, diagonals drive the rails
  always_comb begin
    target        = MIDSCALE;
    shoot_through = (SWIPT_OUT0 & SWIPT_OUT1) | (SWIPT_OUT2 & SWIPT_OUT3);
    if (shoot_through) begin
      target = MIDSCALE;
    end else if (SWIPT_OUT0 & SWIPT_OUT3) begin
      target = FULL;
    end else if (SWIPT_OUT1 & SWIPT_OUT2) begin
      target = ZERO;
    end
  end

  assign diff    = $signed({1'b0, target}) - $signed({1'b0, acc});
  assign shifted = diff >>> K_SHIFT;

  // First-order step with a minimum magnitude of one LSB so the filter lands exactly on target
  always_comb begin
    step = shifted;
    if ((diff != 13'sd0) && (shifted == 13'sd0)) begin
      step = diff[12] ? -13'sd1 : 13'sd1;
    end
  end

  // Filter accumulator; the step never overshoots, so modulo-4096 addition cannot wrap
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      acc <= MIDSCALE;
    end else begin
      acc <= acc + step[11:0];
    end
  end

  // adc_code[11] is the sign-like MSB that feeds the ACOUT0 line at the top level
  assign adc_code = acc;

  // Hysteretic slicer around midscale, forced low while the link is down
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      ADC_comp <= 1'b0;
    end else if (!swipt) begin
      ADC_comp <= 1'b0;
    end else if (acc >= CMP_HI) begin
      ADC_comp <= 1'b1;
    end else if (acc <= CMP_LO) begin
      ADC_comp <= 1'b0;
    end
  end

endmodule

// File: tb/tb_swipt_sense_frontend.sv
// tb/tb_swipt_sense_frontend.sv - directed-vector bench for swipt_sense_frontend
module tb_swipt_sense_frontend;

  logic        clk;
  logic        nrst;
  logic        swiptONHeartbeat;
  logic        SWIPT_OUT0;
  logic        SWIPT_OUT1;
  logic        SWIPT_OUT2;
  logic        SWIPT_OUT3;
  logic        swipt;
  logic [11:0] adc_code;
  logic        ADC_comp;

  int vectors;
  int miscompares;
  bit hb_auto;
  int hb_div;

  swipt_sense_frontend #(
    .HB_TIMEOUT(256),
    .HB_EDGES  (4),
    .K_SHIFT   (4),
    .HYST      (64)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .swiptONHeartbeat(swiptONHeartbeat),
    .SWIPT_OUT0      (SWIPT_OUT0),
    .SWIPT_OUT1      (SWIPT_OUT1),
    .SWIPT_OUT2      (SWIPT_OUT2),
    .SWIPT_OUT3      (SWIPT_OUT3),
    .swipt           (swipt),
    .adc_code        (adc_code),
    .ADC_comp        (ADC_comp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock; inputs change 1 time unit after the rising edge, outputs are read there too
  task automatic tick;
    @(posedge clk);
    #1;
    if (hb_auto) begin
      hb_div++;
      if (hb_div >= 90) begin
        hb_div = 0;
        swiptONHeartbeat = ~swiptONHeartbeat;
      end
    end
  endtask

  // g[0]=OUT0 .. g[3]=OUT3
  task automatic set_gates(input logic [3:0] g);
    SWIPT_OUT0 = g[0];
    SWIPT_OUT1 = g[1];
    SWIPT_OUT2 = g[2];
    SWIPT_OUT3 = g[3];
  endtask

  task automatic test_reset;
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      swiptONHeartbeat = 1'($urandom_range(0, 1));
      set_gates(4'($urandom_range(0, 15)));
      tick;
    end
    vectors++;
    if (swipt !== 1'b0) begin miscompares++; $display("FAIL rst_hold_swipt: got %0b expected 0", swipt); end
    vectors++;
    if (adc_code !== 12'd2048) begin miscompares++; $display("FAIL rst_hold_adc: got %0d expected 2048", adc_code); end
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL rst_hold_comp: got %0b expected 0", ADC_comp); end
    swiptONHeartbeat = 1'b0;
    set_gates(4'b0000);
    nrst = 1'b0;
    tick;
    vectors++;
    if (swipt !== 1'b0) begin miscompares++; $display("FAIL rst_rel_swipt: got %0b expected 0", swipt); end
    vectors++;
    if (adc_code !== 12'd2048) begin miscompares++; $display("FAIL rst_rel_adc: got %0d expected 2048", adc_code); end
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL rst_rel_comp: got %0b expected 0", ADC_comp); end
  endtask

  task automatic test_heartbeat_lock;
    for (int t = 1; t <= 4; t++) begin
      repeat (90) tick;
      vectors++;
      if (swipt !== 1'b0) begin miscompares++; $display("FAIL lock_pre_%0d: got %0b expected 0", t, swipt); end
      swiptONHeartbeat = ~swiptONHeartbeat;
    end
    tick;
    tick;
    vectors++;
    if (swipt !== 1'b0) begin miscompares++; $display("FAIL lock_early: got %0b expected 0", swipt); end
    tick;
    vectors++;
    if (swipt !== 1'b1) begin miscompares++; $display("FAIL lock_rise: got %0b expected 1", swipt); end
    for (int t = 0; t < 4; t++) begin
      repeat (90) tick;
      vectors++;
      if (swipt !== 1'b1) begin miscompares++; $display("FAIL lock_hold_%0d: got %0b expected 1", t, swipt); end
      swiptONHeartbeat = ~swiptONHeartbeat;
    end
  endtask

  // Last toggle lands in s1 one clock later; its edge pulse is sampled 3 clocks after the toggle
  task automatic test_heartbeat_loss;
    repeat (258) tick;
    vectors++;
    if (swipt !== 1'b1) begin miscompares++; $display("FAIL loss_before: got %0b expected 1", swipt); end
    tick;
    vectors++;
    if (swipt !== 1'b0) begin miscompares++; $display("FAIL loss_fall: got %0b expected 0", swipt); end
  endtask

  task automatic test_slow_heartbeat;
    for (int t = 0; t < 6; t++) begin
      repeat (300) tick;
      vectors++;
      if (swipt !== 1'b0) begin miscompares++; $display("FAIL slow_hb_%0d: got %0b expected 0", t, swipt); end
      swiptONHeartbeat = ~swiptONHeartbeat;
    end
    repeat (10) tick;
    vectors++;
    if (swipt !== 1'b0) begin miscompares++; $display("FAIL slow_hb_end: got %0b expected 0", swipt); end
  endtask

  // Drive a gate pattern, check the first code, then require exact convergence and a stable hold
  task automatic filter_run(input string name, input logic [3:0] g,
                            input logic [11:0] first, input logic [11:0] final_code);
    bit found;
    set_gates(g);
    tick;
    vectors++;
    if (adc_code !== first) begin miscompares++; $display("FAIL %s_first: got %0d expected %0d", name, adc_code, first); end
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (adc_code == final_code) found = 1'b1;
      else tick;
      vectors++;
      if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL %s_comp_off: got %0b expected 0", name, ADC_comp); end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL %s_converge: got %0d expected %0d", name, adc_code, final_code); end
    repeat (16) tick;
    vectors++;
    if (adc_code !== final_code) begin miscompares++; $display("FAIL %s_hold: got %0d expected %0d", name, adc_code, final_code); end
  endtask

  task automatic test_filter_step;
    set_gates(4'b1001);
    tick;
    vectors++;
    if (adc_code !== 12'd2175) begin miscompares++; $display("FAIL up_step1: got %0d expected 2175", adc_code); end
    tick;
    vectors++;
    if (adc_code !== 12'd2295) begin miscompares++; $display("FAIL up_step2: got %0d expected 2295", adc_code); end
    filter_run("up", 4'b1001, 12'd2407, 12'd4095);
    filter_run("shoot01", 4'b0011, 12'd3967, 12'd2048);
    filter_run("down", 4'b0110, 12'd1920, 12'd0);
    filter_run("shoot_all", 4'b1111, 12'd128, 12'd2048);
  endtask

  // Wait (bounded) until adc_code reaches a code known to lie on the current trajectory
  task automatic wait_code(input string name, input logic [11:0] code);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (adc_code == code) found = 1'b1;
      else tick;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL %s: got %0d expected %0d", name, adc_code, code); end
  endtask

  task automatic test_comparator;
    bit locked;
    set_gates(4'b0000);
    hb_auto = 1'b1;
    hb_div = 0;
    locked = 1'b0;
    for (int i = 0; i < 600 && !locked; i++) begin
      tick;
      if (swipt == 1'b1) locked = 1'b1;
    end
    vectors++;
    if (!locked) begin miscompares++; $display("FAIL cmp_lock: got %0b expected 1", swipt); end
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL cmp_mid_hold0: got %0b expected 0", ADC_comp); end

    // Rise above band, decay to 2138, then bounce down through 2118 and 1985
    set_gates(4'b1001);
    tick;
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL cmp_lat: got %0b expected 0", ADC_comp); end
    tick;
    vectors++;
    if (ADC_comp !== 1'b1) begin miscompares++; $display("FAIL cmp_set: got %0b expected 1", ADC_comp); end
    set_gates(4'b0000);
    repeat (15) tick;
    vectors++;
    if (adc_code !== 12'd2138) begin miscompares++; $display("FAIL cmp_a_2138: got %0d expected 2138", adc_code); end
    set_gates(4'b1001);
    tick;
    vectors++;
    if (adc_code !== 12'd2260) begin miscompares++; $display("FAIL cmp_a_2260: got %0d expected 2260", adc_code); end
    set_gates(4'b0110);
    tick;
    vectors++;
    if (adc_code !== 12'd2118) begin miscompares++; $display("FAIL cmp_a_2118: got %0d expected 2118", adc_code); end
    tick;
    vectors++;
    if (adc_code !== 12'd1985) begin miscompares++; $display("FAIL cmp_a_1985: got %0d expected 1985", adc_code); end
    tick;
    vectors++;
    if (adc_code !== 12'd1860) begin miscompares++; $display("FAIL cmp_a_1860: got %0d expected 1860", adc_code); end
    vectors++;
    if (ADC_comp !== 1'b1) begin miscompares++; $display("FAIL cmp_hold_1985: got %0b expected 1", ADC_comp); end
    tick;
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL cmp_clr_1860: got %0b expected 0", ADC_comp); end

    // Decay from full scale to 2117, then one negative step lands exactly on 1984
    set_gates(4'b1001);
    wait_code("cmp_b_full", 12'd4095);
    set_gates(4'b0000);
    wait_code("cmp_b_2117", 12'd2117);
    set_gates(4'b0110);
    tick;
    vectors++;
    if (adc_code !== 12'd1984) begin miscompares++; $display("FAIL cmp_b_1984: got %0d expected 1984", adc_code); end
    vectors++;
    if (ADC_comp !== 1'b1) begin miscompares++; $display("FAIL cmp_b_pre: got %0b expected 1", ADC_comp); end
    tick;
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL cmp_clr_1984: got %0b expected 0", ADC_comp); end

    // 2112 -> 2108 -> 1976 -> 1980 -> 2112 exercises the upper threshold from below
    set_gates(4'b1001);
    wait_code("cmp_c_full", 12'd4095);
    set_gates(4'b0000);
    wait_code("cmp_c_2112", 12'd2112);
    tick;
    vectors++;
    if (adc_code !== 12'd2108) begin miscompares++; $display("FAIL cmp_c_2108: got %0d expected 2108", adc_code); end
    set_gates(4'b0110);
    tick;
    vectors++;
    if (adc_code !== 12'd1976) begin miscompares++; $display("FAIL cmp_c_1976: got %0d expected 1976", adc_code); end
    vectors++;
    if (ADC_comp !== 1'b1) begin miscompares++; $display("FAIL cmp_hold_2108: got %0b expected 1", ADC_comp); end
    set_gates(4'b0000);
    tick;
    vectors++;
    if (adc_code !== 12'd1980) begin miscompares++; $display("FAIL cmp_c_1980: got %0d expected 1980", adc_code); end
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL cmp_clr_1976: got %0b expected 0", ADC_comp); end
    set_gates(4'b1001);
    tick;
    vectors++;
    if (adc_code !== 12'd2112) begin miscompares++; $display("FAIL cmp_c_2112b: got %0d expected 2112", adc_code); end
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL cmp_hold_1980: got %0b expected 0", ADC_comp); end
    set_gates(4'b0000);
    tick;
    vectors++;
    if (ADC_comp !== 1'b1) begin miscompares++; $display("FAIL cmp_set_2112: got %0b expected 1", ADC_comp); end
  endtask

  task automatic test_async_reset;
    vectors++;
    if (swipt !== 1'b1) begin miscompares++; $display("FAIL arst_pre_swipt: got %0b expected 1", swipt); end
    nrst = 1'b1;
    #2;
    vectors++;
    if (swipt !== 1'b0) begin miscompares++; $display("FAIL arst_swipt: got %0b expected 0", swipt); end
    vectors++;
    if (adc_code !== 12'd2048) begin miscompares++; $display("FAIL arst_adc: got %0d expected 2048", adc_code); end
    vectors++;
    if (ADC_comp !== 1'b0) begin miscompares++; $display("FAIL arst_comp: got %0b expected 0", ADC_comp); end
    hb_auto = 1'b0;
    set_gates(4'b1001);
    repeat (3) tick;
    vectors++;
    if (adc_code !== 12'd2048) begin miscompares++; $display("FAIL arst_hold_adc: got %0d expected 2048", adc_code); end
    nrst = 1'b0;
    tick;
    vectors++;
    if (adc_code !== 12'd2175) begin miscompares++; $display("FAIL arst_rel_adc: got %0d expected 2175", adc_code); end
    vectors++;
    if (swipt !== 1'b0) begin miscompares++; $display("FAIL arst_rel_swipt: got %0b expected 0", swipt); end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    hb_auto          = 1'b0;
    hb_div           = 0;
    nrst             = 1'b1;
    swiptONHeartbeat = 1'b0;
    set_gates(4'b0000);
    test_reset;
    test_heartbeat_lock;
    test_heartbeat_loss;
    test_slow_heartbeat;
    test_filter_step;
    test_comparator;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
